// File: rtl/cache_pkg.sv
// Shared cache line-format helpers, default geometry and the miss-handler state encoding.
// Line format, MSB to LSB: {dirty, valid, tag, block[N-1] .. block[0]}.
package cache_pkg;

  function automatic int block_offset_length(input int blocks_per_line);
    return $clog2(blocks_per_line);
  endfunction

  function automatic int index_length(input int cache_lines);
    return $clog2(cache_lines);
  endfunction

  function automatic int tag_length(input int address_size, input int blocks_per_line,
                                    input int cache_lines);
    return address_size - index_length(cache_lines) - block_offset_length(blocks_per_line);
  endfunction

  function automatic int cache_line_length(input int block_size, input int blocks_per_line,
                                           input int address_size, input int cache_lines);
    return 2 + tag_length(address_size, blocks_per_line, cache_lines)
             + blocks_per_line * block_size;
  endfunction

  localparam int DEFAULT_BLOCK_SIZE             = 4;
  localparam int DEFAULT_NUM_OF_BLOCKS_PER_LINE = 2;
  localparam int DEFAULT_NUM_OF_CACHE_LINES     = 4;
  localparam int DEFAULT_ADDRESS_SIZE           = 16;

  localparam int BLOCK_OFFSET_LENGTH = block_offset_length(DEFAULT_NUM_OF_BLOCKS_PER_LINE);
  localparam int INDEX_LENGTH        = index_length(DEFAULT_NUM_OF_CACHE_LINES);
  localparam int TAG_LENGTH          = tag_length(DEFAULT_ADDRESS_SIZE,
                                                  DEFAULT_NUM_OF_BLOCKS_PER_LINE,
                                                  DEFAULT_NUM_OF_CACHE_LINES);
  localparam int CACHE_LINE_LENGTH   = cache_line_length(DEFAULT_BLOCK_SIZE,
                                                         DEFAULT_NUM_OF_BLOCKS_PER_LINE,
                                                         DEFAULT_ADDRESS_SIZE,
                                                         DEFAULT_NUM_OF_CACHE_LINES);
  localparam int DIRTY_BIT_INDEX     = CACHE_LINE_LENGTH - 1;
  localparam int VALID_BIT_INDEX     = CACHE_LINE_LENGTH - 2;
  // Tag LSB position; the tag occupies [TAG_INDEX +: TAG_LENGTH].
  localparam int TAG_INDEX           = DEFAULT_NUM_OF_BLOCKS_PER_LINE * DEFAULT_BLOCK_SIZE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/cache_miss_handler.sv
// Services one cache miss: optional write-back of a dirty victim, line refill, one-cycle commit.
// Memory handshake: a beat is presented while mem_req=1 and completes on a rising edge with mem_ack=1.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int BLOCK_SIZE             = DEFAULT_BLOCK_SIZE,
  parameter int NUM_OF_BLOCKS_PER_LINE = DEFAULT_NUM_OF_BLOCKS_PER_LINE,
  parameter int NUM_OF_CACHE_LINES     = DEFAULT_NUM_OF_CACHE_LINES,
  parameter int ADDRESS_SIZE           = DEFAULT_ADDRESS_SIZE,
  localparam int LINE_LEN = cache_line_length(BLOCK_SIZE, NUM_OF_BLOCKS_PER_LINE,
                                              ADDRESS_SIZE, NUM_OF_CACHE_LINES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    miss,
  input  logic [ADDRESS_SIZE-1:0] miss_address,
  input  logic [LINE_LEN-1:0]     victim_line,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0]   mem_wdata,
  input  logic [BLOCK_SIZE-1:0]   mem_rdata,
  input  logic                    mem_ack,
  output logic [LINE_LEN-1:0]     line_o,
  output logic                    write_line,
  output logic                    busy,
  output state_t                  fsm_state
);

  localparam int OFF_LEN   = block_offset_length(NUM_OF_BLOCKS_PER_LINE);
  localparam int TAG_LEN   = tag_length(ADDRESS_SIZE, NUM_OF_BLOCKS_PER_LINE, NUM_OF_CACHE_LINES);
  localparam int DIRTY_IDX = LINE_LEN - 1;
  localparam int VALID_IDX = LINE_LEN - 2;
  localparam int DATA_W    = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;
  localparam int CNT_W     = (OFF_LEN > 0) ? OFF_LEN : 1;
  localparam logic [CNT_W-1:0] LAST_OFFSET = CNT_W'(NUM_OF_BLOCKS_PER_LINE - 1);
  localparam logic [ADDRESS_SIZE-1:0] LOW_MASK = ADDRESS_SIZE'((1 << (ADDRESS_SIZE - TAG_LEN)) - 1);
  localparam logic [ADDRESS_SIZE-1:0] OFF_MASK = ADDRESS_SIZE'((1 << OFF_LEN) - 1);

  state_t                  state, next_state;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [TAG_LEN-1:0]      victim_tag_q;
  logic [DATA_W-1:0]       victim_blocks_q;
  logic [DATA_W-1:0]       fill_q, fill_next;
  logic [LINE_LEN-1:0]     line_q;
  logic [CNT_W-1:0]        offset;
  logic [TAG_LEN-1:0]      miss_tag, tag_sel;
  logic [ADDRESS_SIZE-1:0] beat_base;
  logic                    beat_done, last_beat;

  assign miss_tag  = addr_q[ADDRESS_SIZE-1 -: TAG_LEN];
  assign beat_done = mem_req && mem_ack;
  assign last_beat = (offset == LAST_OFFSET);
  assign fsm_state = state;
  assign line_o    = line_q;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (miss) next_state = (victim_line[DIRTY_IDX] && victim_line[VALID_IDX]) ? WB : FILL;
      WB:     if (beat_done && last_beat) next_state = FILL;
      FILL:   if (beat_done && last_beat) next_state = COMMIT;
      COMMIT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so an asynchronous reset clears them without a clock edge.
  always_comb begin
    busy       = (state != IDLE);
    mem_req    = (state == WB) || (state == FILL);
    mem_we     = (state == WB);
    write_line = (state == COMMIT);
    tag_sel    = (state == WB) ? victim_tag_q : miss_tag;
    beat_base  = (addr_q & LOW_MASK) | (ADDRESS_SIZE'(tag_sel) << (ADDRESS_SIZE - TAG_LEN));
    mem_addr   = mem_req ? ((beat_base & ~OFF_MASK) | ADDRESS_SIZE'(offset)) : '0;
    mem_wdata  = (state == WB) ? BLOCK_SIZE'(victim_blocks_q >> (int'(offset) * BLOCK_SIZE)) : '0;
    fill_next  = fill_q;
    fill_next[int'(offset) * BLOCK_SIZE +: BLOCK_SIZE] = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      victim_tag_q    <= '0;
      victim_blocks_q <= '0;
      fill_q          <= '0;
      line_q          <= '0;
      offset          <= '0;
    end else begin
      if (state == IDLE && miss) begin
        addr_q          <= miss_address;
        victim_tag_q    <= victim_line[DATA_W +: TAG_LEN];
        victim_blocks_q <= victim_line[DATA_W-1:0];
        offset          <= '0;
      end
      if (beat_done) begin
        offset <= last_beat ? '0 : offset + CNT_W'(1);
        if (state == FILL) begin
          fill_q <= fill_next;
          if (last_beat) line_q <= {1'b0, 1'b1, miss_tag, fill_next};
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler at default geometry (13-bit tag, 23-bit line).
module tb_cache_miss_handler;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss = 1'b0;
  logic [15:0] miss_address = '0;
  logic [22:0] victim_line = '0;
  logic [3:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, write_line, busy;
  logic [15:0] mem_addr;
  logic [3:0]  mem_wdata;
  logic [22:0] line_o;
  state_t      fsm_state;

  int errors = 0;
  int checks = 0;

  cache_miss_handler dut (
    .clk(clk), .rst_n(rst_n), .miss(miss), .miss_address(miss_address),
    .victim_line(victim_line), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .line_o(line_o),
    .write_line(write_line), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_line"}, 32'(line_o), 32'd0);
    check({tag, "_wl"}, 32'(write_line), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Present a miss for one rising edge; returns at the following falling edge.
  task automatic start_miss(input logic [15:0] addr, input logic [22:0] victim);
    miss = 1'b1;
    miss_address = addr;
    victim_line = victim;
    @(negedge clk);
    miss = 1'b0;
  endtask

  // One beat, checked on entry; waits = cycles of mem_ack=0 before the acking edge.
  task automatic beat(input string tag, input logic we, input logic [15:0] addr,
                      input logic [3:0] wdata, input logic [3:0] rdata, input int waits);
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_we"}, 32'(mem_we), 32'(we));
    check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    if (we) check({tag, "_wdata"}, 32'(mem_wdata), 32'(wdata));
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      @(negedge clk);
      check({tag, "_hold_req"}, 32'(mem_req), 32'd1);
      check({tag, "_hold_addr"}, 32'(mem_addr), 32'(addr));
      check({tag, "_hold_wdata"}, 32'(mem_wdata), we ? 32'(wdata) : 32'd0);
    end
    mem_ack = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic commit(input string tag, input logic [22:0] exp_line);
    check({tag, "_wl"}, 32'(write_line), 32'd1);
    check({tag, "_line"}, 32'(line_o), 32'(exp_line));
    check({tag, "_req_off"}, 32'(mem_req), 32'd0);
    @(negedge clk);
    check({tag, "_wl_once"}, 32'(write_line), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_line_hold"}, 32'(line_o), 32'(exp_line));
  endtask

  initial begin
    // Reset held: every output zero.
    repeat (2) @(negedge clk);
    outputs_zero("rst");
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Stray ack while idle is ignored.
    mem_ack = 1'b1;
    @(negedge clk);
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    // Clean miss, invalid victim, zero-wait memory.
    start_miss(16'h0015, 23'h0);
    beat("clean_r0", 1'b0, 16'h0014, 4'h0, 4'hA, 0);
    beat("clean_r1", 1'b0, 16'h0015, 4'h0, 4'h5, 0);
    commit("clean", {1'b0, 1'b1, 13'h0002, 4'h5, 4'hA});

    // Dirty victim: two write beats, then the refill.
    start_miss(16'h0015, {1'b1, 1'b1, 13'h0007, 4'h3, 4'hC});
    beat("dirty_w0", 1'b1, 16'h003C, 4'hC, 4'h0, 0);
    beat("dirty_w1", 1'b1, 16'h003D, 4'h3, 4'h0, 0);
    beat("dirty_r0", 1'b0, 16'h0014, 4'h0, 4'h7, 0);
    beat("dirty_r1", 1'b0, 16'h0015, 4'h0, 4'h9, 0);
    commit("dirty", {1'b0, 1'b1, 13'h0002, 4'h9, 4'h7});

    // Wait states: three idle cycles before every ack, different index and tag.
    start_miss(16'h0123, 23'h0);
    beat("wait_r0", 1'b0, 16'h0122, 4'h0, 4'h1, 3);
    beat("wait_r1", 1'b0, 16'h0123, 4'h0, 4'hE, 3);
    commit("wait", {1'b0, 1'b1, 13'h0024, 4'hE, 4'h1});

    // Dirty victim with wait states: write data must hold while waiting.
    start_miss(16'h0008, {1'b1, 1'b1, 13'h1FFF, 4'h6, 4'hB});
    beat("dwait_w0", 1'b1, 16'hFFF8, 4'hB, 4'h0, 2);
    beat("dwait_w1", 1'b1, 16'hFFF9, 4'h6, 4'h0, 1);
    beat("dwait_r0", 1'b0, 16'h0008, 4'h0, 4'h2, 0);
    beat("dwait_r1", 1'b0, 16'h0009, 4'h0, 4'h4, 0);
    commit("dwait", {1'b0, 1'b1, 13'h0001, 4'h4, 4'h2});

    // Valid clean victim, miss held high while busy with a different address offered.
    miss = 1'b1;
    miss_address = 16'h0015;
    victim_line = {1'b0, 1'b1, 13'h0007, 4'h3, 4'hC};
    @(negedge clk);
    miss_address = 16'h00FF;
    victim_line = {1'b1, 1'b1, 13'h0005, 4'h1, 4'h1};
    beat("busy_r0", 1'b0, 16'h0014, 4'h0, 4'h8, 0);
    beat("busy_r1", 1'b0, 16'h0015, 4'h0, 4'h6, 0);
    check("busy_wl", 32'(write_line), 32'd1);
    check("busy_line", 32'(line_o), 32'({1'b0, 1'b1, 13'h0002, 4'h6, 4'h8}));
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
    miss = 1'b0;
    @(negedge clk);
    check("busy_no_second", 32'(busy), 32'd0);

    // Reset in the middle of a refill beat.
    start_miss(16'h0015, 23'h0);
    check("abort_req_before", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    outputs_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_wl", 32'(write_line), 32'd0);
    end

    // New miss accepted on the first edge after reset release.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_miss(16'h0006, 23'h0);
    beat("post_r0", 1'b0, 16'h0006, 4'h0, 4'hD, 0);
    beat("post_r1", 1'b0, 16'h0007, 4'h0, 4'h3, 0);
    commit("post", {1'b0, 1'b1, 13'h0000, 4'h3, 4'hD});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_miss_handler.md
CACHE_MISS_HANDLER -- requirements
Module: cache_miss_handler

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 4: bits per block and per memory beat.
REQ-002 SHALL have parameter NUM_OF_BLOCKS_PER_LINE, default 2: blocks per cache line; power of two.
REQ-003 SHALL have parameter NUM_OF_CACHE_LINES, default 4: cache lines; power of two.
REQ-004 SHALL have parameter ADDRESS_SIZE, default 16: block-address width, fields {tag, index, block_offset}, MSB to LSB.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port miss, input, 1: cache miss request, level.
REQ-008 SHALL have port miss_address, input, ADDRESS_SIZE: address that missed.
REQ-009 SHALL have port victim_line, input, CACHE_LINE_LENGTH: current line at the miss index, format {dirty, valid, tag, block[N-1]..block[0]}, block 0 in the LSBs.
REQ-010 SHALL have port mem_req, output, 1: memory beat request.
REQ-011 SHALL have port mem_we, output, 1: 1 = write beat, 0 = read beat.
REQ-012 SHALL have port mem_addr, output, ADDRESS_SIZE: beat block address.
REQ-013 SHALL have port mem_wdata, output, BLOCK_SIZE: write-beat data.
REQ-014 SHALL have port mem_rdata, input, BLOCK_SIZE: read-beat data, valid with mem_ack.
REQ-015 SHALL have port mem_ack, input, 1: beat completes on an edge where mem_req && mem_ack.
REQ-016 SHALL have port line_o, output, CACHE_LINE_LENGTH: refilled line for the cache line_i.
REQ-017 SHALL have port write_line, output, 1: one-cycle strobe; line_o valid.
REQ-018 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-019 SHALL implement the FSM IDLE -> WB (only if victim valid && dirty) -> FILL -> COMMIT -> IDLE.
REQ-020 SHALL, in IDLE on an edge with miss=1, latch miss_address and victim_line; miss is ignored in every other state.
REQ-021 SHALL, in WB, issue N write beats, offsets 0..N-1: mem_addr = {victim tag, miss index, offset}, mem_wdata = victim block[offset].
REQ-022 SHALL, in FILL, issue N read beats, offsets 0..N-1: mem_addr = {miss tag, miss index, offset}; capture mem_rdata into block[offset].
REQ-023 SHALL drive mem_req high from the cycle after state entry; mem_addr, mem_we and mem_wdata stay stable until the beat completes.
REQ-024 SHALL present the next beat in the cycle after an ack, with mem_req allowed to remain high; wait states are unbounded.
REQ-025 SHALL ignore mem_ack while mem_req=0.
REQ-026 SHALL, in COMMIT, drive write_line=1 for exactly one cycle, with line_o = {dirty 0, valid 1, miss tag, filled blocks}; line_o holds until the next COMMIT.
REQ-027 SHALL meet this latency with zero-wait memory: miss accepted at edge k; write_line high in the cycle after edge k+N (clean victim) or k+2N (dirty victim).
REQ-028 SHALL use an offset counter of width max(1, BLOCK_OFFSET_LENGTH) that wraps to 0 on leaving WB or FILL.
REQ-029 SHALL skip WB for an invalid victim or a valid, clean victim.

Reset
REQ-030 SHALL, on rst_n=0 at any time (including mid-beat), go to IDLE immediately and force mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, line_o=0, write_line=0, busy=0.
REQ-031 SHALL NOT emit write_line for an operation aborted by reset, and SHALL accept a new miss on the first edge after release.

Structure
REQ-032 SHALL take the derived line-format constants from the shared package cache_pkg: BLOCK_OFFSET_LENGTH, INDEX_LENGTH, TAG_LENGTH, CACHE_LINE_LENGTH, DIRTY_BIT_INDEX, VALID_BIT_INDEX, TAG_INDEX. The state encoding typedef SHALL also live in cache_pkg.
REQ-033 SHALL be a single module; no sub-module is warranted.

Verification (defaults: TAG_LENGTH 13, CACHE_LINE_LENGTH 23)
REQ-034 SHALL cover reset: hold rst_n=0 -> every output 0; assert rst_n=0 mid-FILL -> mem_req falls with no clock edge and no write_line follows.
REQ-035 SHALL cover a clean miss: miss_address 0x0015, invalid victim, zero-wait memory returning 0xA at 0x0014 and 0x5 at 0x0015 -> reads at 0x0014 then 0x0015, then write_line once with line_o = {0, 1, 13'h0002, 4'h5, 4'hA}.
REQ-036 SHALL cover a dirty victim: victim {1, 1, tag 0x0007, blocks 0x3, 0xC}, miss 0x0015 -> writes 0xC@0x003C and 0x3@0x003D, then reads at 0x0014 and 0x0015.
REQ-037 SHALL cover wait states: mem_ack delayed 3 cycles on every beat -> mem_addr and mem_wdata stable while waiting, exactly 2 beats, a single write_line.
REQ-038 SHALL cover miss while busy and a clean victim: miss held high through FILL -> no second operation before IDLE; a valid, clean victim -> no write beats.
